systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (array is N x N, inner dimension K = N).
REQ-002 SHALL have parameter DW, default 8: signed operand width.
REQ-003 SHALL have parameter DRAIN_CYC, default 2*N: cycles waited after streaming before results are declared valid.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1: operand buffer write strobe.
REQ-007 SHALL have port wr_sel, input, 1: buffer select for a write (0 = A, 1 = B).
REQ-008 SHALL have port wr_row, input, clog2(N): row index for a write.
REQ-009 SHALL have port wr_col, input, clog2(N): column index for a write.
REQ-010 SHALL have port wr_data, input, DW signed: operand value for a write.
REQ-011 SHALL have port start, input, 1: request one matrix multiply.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted through the DRAIN state.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when array results are valid.
REQ-014 SHALL have port wr_err, output, 1: sticky flag, set by any write attempted while busy.
REQ-015 SHALL have port arr_clear, output, 1: accumulator clear, driven to the array's clear input.
REQ-016 SHALL have port a_feed, output, N*DW: row operands; slice i drives array row i.
REQ-017 SHALL have port b_feed, output, N*DW: column operands; slice j drives array column j.

Function
REQ-018 SHALL hold two N x N operand buffers, A and B; a write with wr_en=1 and busy=0 stores wr_data at [wr_row][wr_col] of the buffer chosen by wr_sel.
REQ-019 SHALL ignore writes while busy=1 or while start is being accepted, leave the buffers unchanged, and set wr_err; wr_err clears only on reset.
REQ-020 SHALL implement the FSM IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-021 SHALL accept start only in IDLE; start in any other state is ignored with no queuing.
REQ-022 SHALL remain in CLEAR for exactly 1 cycle with arr_clear=1; arr_clear SHALL be 0 in all other states.
REQ-023 SHALL remain in STREAM for exactly 2N-1 cycles, indexed by a counter t = 0..2N-2.
REQ-024 SHALL drive a_feed slice i, in STREAM cycle t, to A[i][t-i] when 0 <= t-i < N, and to 0 otherwise.
REQ-025 SHALL drive b_feed slice j, in STREAM cycle t, to B[t-j][j] when 0 <= t-j < N, and to 0 otherwise.
REQ-026 SHALL drive a_feed and b_feed to all zeros in every state other than STREAM, so that zero operands enter the array.
REQ-027 SHALL remain in DRAIN for exactly DRAIN_CYC cycles, then spend 1 cycle in DONE with done=1 before returning to IDLE.
REQ-028 SHALL have a fixed latency of 1+(2N-1)+DRAIN_CYC+1 cycles from the start-accept edge to the done pulse; this is 4N+1 cycles with default parameters (17 cycles for N=4).
REQ-029 SHALL keep busy=1 in CLEAR, STREAM and DRAIN, and busy=0 in IDLE and DONE.
REQ-030 SHALL not modify the operand buffers during a run; a new start reuses the current buffer contents.
REQ-031 SHALL permit start in the cycle immediately after DONE, i.e. back-to-back runs separated by one IDLE cycle.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-run, immediately force state=IDLE, t=0, busy=0, done=0, arr_clear=0, wr_err=0, a_feed=0 and b_feed=0.
REQ-033 SHALL not reset the operand buffer contents; their contents after reset are unspecified until rewritten.
REQ-034 SHALL, after rst deasserts, accept start on the first clock edge.

Verification
REQ-035 SHALL verify identity x B: A=I and B[r][c]=4r+c for N=4 -> done exactly 17 cycles after start; the array output C equals B.
REQ-036 SHALL verify skew: A[i][k]=10i+k and B=0 -> in STREAM t=3, a_feed = {A[0][3], A[1][2], A[2][1], A[3][0]} = {3, 12, 21, 30}; at t=0, slices 1..3 are 0.
REQ-037 SHALL verify signed values: A=all -128 and B=all -1 -> every C entry equals +512; arr_clear is high for exactly 1 cycle per run.
REQ-038 SHALL verify ignored requests: start pulsed during STREAM and a write during DRAIN -> no second run, buffers unchanged, wr_err=1.
REQ-039 SHALL verify reset mid-run: rst asserted in STREAM t=2 -> all outputs 0 immediately; after release, a restart completes with correct results.
REQ-040 SHALL verify back-to-back runs: start asserted in the cycle after done -> second done 17 cycles later, with C not accumulating the first run's result.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: operand buffers plus the skewed feed sequencer for an
// N x N output-stationary systolic array (C = A x B, inner dimension N).
module systolic_ctrl #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int DRAIN_CYC = 2*N
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic                                 wr_sel,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_row,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_col,
    input  logic signed [DW-1:0]                 wr_data,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 wr_err,
    output logic                                 arr_clear,
    output logic [N*DW-1:0]                      a_feed,
    output logic [N*DW-1:0]                      b_feed
);

    localparam int IW         = (N > 1) ? $clog2(N) : 1;
    localparam int TW         = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam int DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int LAST_T     = 2*N - 2;
    localparam int DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         tCnt_q;
    logic [DCW-1:0]        drainCnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  arrClear_q;
    logic                  wrErr_q;

    logic signed [DW-1:0]  bufA_q [N][N];
    logic signed [DW-1:0]  bufB_q [N][N];

    logic                  startAccept;
    logic                  wrAccept;
    logic [N*DW-1:0]       aFeed;
    logic [N*DW-1:0]       bFeed;
    int                    diff;

    // A write lands only when no run is active and no run is starting this cycle.
    assign startAccept = (state_q == IDLE) && start;
    assign wrAccept    = wr_en && !busy_q && !startAccept;

    // Operand buffers are plain storage with no reset, written from the host side only.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            if (wr_sel) begin
                bufB_q[wr_row][wr_col] <= wr_data;
            end else begin
                bufA_q[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Run sequencer: walks IDLE-CLEAR-STREAM-DRAIN-DONE and registers the control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tCnt_q     <= '0;
            drainCnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arrClear_q <= 1'b0;
            wrErr_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            arrClear_q <= 1'b0;
            if (wr_en && (busy_q || startAccept)) begin
                wrErr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        arrClear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= STREAM;
                    tCnt_q  <= '0;
                end
                STREAM: begin
                    if (tCnt_q == TW'(LAST_T)) begin
                        tCnt_q <= '0;
                        if (DRAIN_CYC == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= DRAIN;
                            drainCnt_q <= '0;
                        end
                    end else begin
                        tCnt_q <= tCnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == DCW'(DRAIN_LAST)) begin
                        drainCnt_q <= '0;
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        drainCnt_q <= drainCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Skewed feeds: row i / column j see element k = t-i (t-j) so operands meet at PE(i,j) in step.
    always_comb begin
        aFeed = '0;
        bFeed = '0;
        diff  = 0;
        if (state_q == STREAM) begin
            for (int i = 0; i < N; i++) begin
                diff = int'(tCnt_q) - i;
                if (diff >= 0 && diff < N) begin
                    aFeed[i*DW +: DW] = bufA_q[IW'(i)][diff[IW-1:0]];
                    bFeed[i*DW +: DW] = bufB_q[diff[IW-1:0]][IW'(i)];
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_err    = wrErr_q;
    assign arr_clear = arrClear_q;
    assign a_feed    = aFeed;
    assign b_feed    = bFeed;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: drives systolic_ctrl, models the attached output-stationary
// array from the feeds it produces, and compares against plain matrix products.
module tb_systolic_ctrl;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int DRAIN_CYC = 2*N;
    localparam int IW        = 2;
    localparam int LAT       = 1 + (2*N - 1) + DRAIN_CYC + 1;

    logic                  clk;
    logic                  rst;
    logic                  wr_en;
    logic                  wr_sel;
    logic [IW-1:0]         wr_row;
    logic [IW-1:0]         wr_col;
    logic signed [DW-1:0]  wr_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  wr_err;
    logic                  arr_clear;
    logic [N*DW-1:0]       a_feed;
    logic [N*DW-1:0]       b_feed;

    int     checks;
    int     errors;
    int     mA [N][N];
    int     mB [N][N];
    longint acc [N][N];
    int     aReg [N][N];
    int     bReg [N][N];
    int     nA [N][N];
    int     nB [N][N];

    typedef struct {
        int              t;
        logic [N*DW-1:0] expA;
        logic [N*DW-1:0] expB;
    } skewVec_t;

    skewVec_t skewTab [7];

    systolic_ctrl #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err),
        .arr_clear (arr_clear),
        .a_feed    (a_feed),
        .b_feed    (b_feed)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Array model: PEs pass a right and b down and accumulate a*b; values are stable at the falling edge.
    always @(negedge clk) begin
        if (arr_clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j]  = 0;
                    aReg[i][j] = 0;
                    bReg[i][j] = 0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (j == 0) nA[i][j] = int'($signed(a_feed[i*DW +: DW]));
                    else        nA[i][j] = aReg[i][j-1];
                    if (i == 0) nB[i][j] = int'($signed(b_feed[j*DW +: DW]));
                    else        nB[i][j] = bReg[i-1][j];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j]  = acc[i][j] + longint'(nA[i][j]) * longint'(nB[i][j]);
                    aReg[i][j] = nA[i][j];
                    bReg[i][j] = nB[i][j];
                end
            end
        end
    end

    // Compare one observed value against its expected value and record the outcome.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then return the strobes to idle.
    task automatic applyStimulus(input logic wrEn, input logic wrSel, input int row, input int col,
                                 input int data, input logic startV);
        wr_en   = wrEn;
        wr_sel  = wrSel;
        wr_row  = IW'(row);
        wr_col  = IW'(col);
        wr_data = DW'(data);
        start   = startV;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic loadMatrices();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                applyStimulus(1'b1, 1'b0, i, j, mA[i][j], 1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                applyStimulus(1'b1, 1'b1, i, j, mB[i][j], 1'b0);
    endtask

    task automatic randomMatrices();
        logic signed [DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                v = DW'($urandom);
                mA[i][j] = v;
                v = DW'($urandom);
                mB[i][j] = v;
            end
        end
    endtask

    function automatic longint refC(input int i, input int j);
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s = s + longint'(mA[i][k]) * longint'(mB[k][j]);
        return s;
    endfunction

    function automatic logic [N*DW-1:0] expFeedA(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(mA[i][t-i]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] expFeedB(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(mB[t-j][j]);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // One full run: mode 0 plain, 1 = start in STREAM and write in DRAIN, 2 = write together with start.
    task automatic runAndCheck(input string tag, input int mode, input bit checkC);
        int clears;
        int latency;
        logic [N*DW-1:0] ea;
        logic [N*DW-1:0] eb;
        clears  = 0;
        latency = -1;
        if (mode == 2) applyStimulus(1'b1, 1'b0, 0, 0, mA[0][0] ^ 1, 1'b1);
        else           applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        for (int n = 1; n <= LAT; n++) begin
            if (n >= 2 && n <= 2*N) begin
                ea = expFeedA(n - 2);
                eb = expFeedB(n - 2);
            end else begin
                ea = '0;
                eb = '0;
            end
            checkOutput($sformatf("%s busy n=%0d", tag, n), longint'(busy), (n < LAT) ? 1 : 0);
            checkOutput($sformatf("%s done n=%0d", tag, n), longint'(done), (n == LAT) ? 1 : 0);
            checkOutput($sformatf("%s arr_clear n=%0d", tag, n), longint'(arr_clear), (n == 1) ? 1 : 0);
            checkOutput($sformatf("%s a_feed n=%0d", tag, n), longint'(a_feed), longint'(ea));
            checkOutput($sformatf("%s b_feed n=%0d", tag, n), longint'(b_feed), longint'(eb));
            if (done && latency < 0) latency = n;
            if (arr_clear) clears++;
            if (n < LAT) begin
                if (mode == 1 && n == 4)       applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
                else if (mode == 1 && n == 12) applyStimulus(1'b1, 1'b0, 0, 0, mA[0][0] ^ 1, 1'b0);
                else                           idleCycle();
            end
        end
        checkOutput({tag, " latency"}, latency, LAT);
        checkOutput({tag, " clear cycles"}, clears, 1);
        if (checkC) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    checkOutput($sformatf("%s C[%0d][%0d]", tag, i, j), acc[i][j], refC(i, j));
        end
    endtask

    // Main sequence: reset, directed corner cases, then randomized runs.
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        start   = 1'b0;

        skewTab[0].expA = pk(0, 0, 0, 0);
        skewTab[1].expA = pk(1, 10, 0, 0);
        skewTab[2].expA = pk(2, 11, 20, 0);
        skewTab[3].expA = pk(3, 12, 21, 30);
        skewTab[4].expA = pk(0, 13, 22, 31);
        skewTab[5].expA = pk(0, 0, 23, 32);
        skewTab[6].expA = pk(0, 0, 0, 33);
        for (int e = 0; e < 7; e++) begin
            skewTab[e].t    = e;
            skewTab[e].expB = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", longint'(busy), 0);
        checkOutput("reset done", longint'(done), 0);
        checkOutput("reset arr_clear", longint'(arr_clear), 0);
        checkOutput("reset wr_err", longint'(wr_err), 0);
        checkOutput("reset a_feed", longint'(a_feed), 0);
        checkOutput("reset b_feed", longint'(b_feed), 0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mA[i][j] = (i == j) ? 1 : 0;
                mB[i][j] = 4*i + j;
            end
        end
        loadMatrices();
        runAndCheck("identity", 0, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("identity C=B [%0d][%0d]", i, j), acc[i][j], 4*i + j);
        checkOutput("identity wr_err", longint'(wr_err), 0);

        idleCycle();
        runAndCheck("back2back", 0, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("back2back C=B [%0d][%0d]", i, j), acc[i][j], 4*i + j);

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                mA[i][k] = 10*i + k;
                mB[i][k] = 0;
            end
        end
        loadMatrices();
        begin
            int n;
            applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
            n = 1;
            for (int e = 0; e < 7; e++) begin
                while (n < skewTab[e].t + 2) begin
                    idleCycle();
                    n++;
                end
                checkOutput($sformatf("skew a_feed t=%0d", skewTab[e].t), longint'(a_feed), longint'(skewTab[e].expA));
                checkOutput($sformatf("skew b_feed t=%0d", skewTab[e].t), longint'(b_feed), longint'(skewTab[e].expB));
            end
            while (n < LAT) begin
                idleCycle();
                n++;
            end
            checkOutput("skew done", longint'(done), 1);
        end

        idleCycle();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mA[i][j] = -128;
                mB[i][j] = -1;
            end
        end
        loadMatrices();
        runAndCheck("signed", 0, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("signed C[%0d][%0d]=512", i, j), acc[i][j], 512);

        idleCycle();
        randomMatrices();
        loadMatrices();
        runAndCheck("ignored", 1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            idleCycle();
            checkOutput($sformatf("no second run busy c=%0d", c), longint'(busy), 0);
        end
        checkOutput("ignored wr_err", longint'(wr_err), 1);
        runAndCheck("after ignored", 0, 1'b1);

        idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1);
        repeat (3) idleCycle();
        checkOutput("midrun busy before reset", longint'(busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("midrun reset busy", longint'(busy), 0);
        checkOutput("midrun reset done", longint'(done), 0);
        checkOutput("midrun reset arr_clear", longint'(arr_clear), 0);
        checkOutput("midrun reset wr_err", longint'(wr_err), 0);
        checkOutput("midrun reset a_feed", longint'(a_feed), 0);
        checkOutput("midrun reset b_feed", longint'(b_feed), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        randomMatrices();
        loadMatrices();
        runAndCheck("restart", 0, 1'b1);

        idleCycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        runAndCheck("first edge", 0, 1'b0);

        idleCycle();
        randomMatrices();
        loadMatrices();
        runAndCheck("write with start", 2, 1'b1);
        checkOutput("write with start wr_err", longint'(wr_err), 1);

        for (int r = 0; r < 3; r++) begin
            idleCycle();
            randomMatrices();
            loadMatrices();
            runAndCheck($sformatf("random%0d", r), 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
